// File: rtl/arbitrated_mux.sv
// N-input registered mux with valid/ready on each input and on the output. Selection is addressed or round-robin.
// Optional ARBMUX_COUNT_EN adds per-channel saturating transfer counters on grant_cnt.
module arbitrated_mux #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          addr,
    input  logic [NUM_IN*WIDTH-1:0]   in_data,
    input  logic [NUM_IN-1:0]         in_valid,
    output logic [NUM_IN-1:0]         in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef ARBMUX_COUNT_EN
    ,
    output logic [16*NUM_IN-1:0]      grant_cnt
`endif
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t            state;
    state_t            state_next;
    logic              can_load;
    logic              sel_hit;
    logic              transfer;
    logic [SEL_W-1:0]  sel;
    logic [SEL_W-1:0]  rr_cand;
    logic [SEL_W-1:0]  last;
    logic [NUM_IN-1:0] grant;
    logic [WIDTH-1:0]  chan_data [NUM_IN];

    for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
        assign chan_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    // Handshake: a word moves on channel i in any cycle where in_valid[i] and in_ready[i]
    // are both high; the output word is consumed when out_valid and out_ready are both high.
    always_comb begin
        sel      = '0;
        sel_hit  = 1'b0;
        rr_cand  = '0;
        grant    = '0;
        can_load = (state == EMPTY) || out_ready;
        if (!mode) begin
            if (32'(addr) < NUM_IN) begin
                sel     = addr;
                sel_hit = in_valid[addr];
            end
        end else begin
            // Walk from the farthest offset down so the nearest requester after last wins.
            for (int off = NUM_IN; off >= 1; off--) begin
                rr_cand = SEL_W'((32'(last) + 32'(off)) % NUM_IN);
                if (in_valid[rr_cand]) begin
                    sel     = rr_cand;
                    sel_hit = 1'b1;
                end
            end
        end
        if (sel_hit && can_load && !reset) begin
            grant[sel] = 1'b1;
        end
    end

    assign transfer  = |grant;
    assign in_ready  = grant;
    assign out_valid = (state == FULL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (transfer) begin
            state_next = FULL;
        end else if (state == FULL && out_ready) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data <= '0;
            out_chan <= '0;
            last     <= SEL_W'(NUM_IN - 1);
        end else if (transfer) begin
            out_data <= chan_data[sel];
            out_chan <= sel;
            // Only round-robin transfers advance the fairness pointer.
            if (mode) begin
                last <= sel;
            end
        end
    end

`ifdef ARBMUX_COUNT_EN
    for (genvar i = 0; i < NUM_IN; i++) begin : g_cnt
        logic [15:0] cnt;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt <= '0;
            end else if (grant[i] && cnt != 16'hFFFF) begin
                cnt <= cnt + 16'd1;
            end
        end
        assign grant_cnt[i*16 +: 16] = cnt;
    end
`endif

endmodule

// File: tb/tb_arbitrated_mux.sv
// Directed and random checks of arbitrated_mux against a cycle model whose expected words live in exp_q.
// A second 3-input instance covers out-of-range addresses and non-power-of-two wrap.
module tb_arbitrated_mux;
    localparam int WIDTH  = 8;
    localparam int NUM_IN = 4;
    localparam int SEL_W  = 2;
    localparam int W      = SEL_W + WIDTH;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    mode;
    logic [SEL_W-1:0]        addr;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_chan;
    logic                    out_valid;
    logic                    out_ready;

    logic                    d3_mode;
    logic [1:0]              d3_addr;
    logic [3*WIDTH-1:0]      d3_in_data;
    logic [2:0]              d3_in_valid;
    logic [2:0]              d3_in_ready;
    logic [WIDTH-1:0]        d3_out_data;
    logic [1:0]              d3_out_chan;
    logic                    d3_out_valid;
    logic                    d3_out_ready;
`ifdef ARBMUX_COUNT_EN
    logic [16*NUM_IN-1:0]    grant_cnt;
    logic [47:0]             d3_grant_cnt;
`endif

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];
    logic [SEL_W-1:0] m_last;
    logic [WIDTH-1:0] h_data;
    logic [SEL_W-1:0] h_chan;
    logic [SEL_W-1:0] rr_seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [SEL_W-1:0] sp_seq [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
    logic [1:0]       d3_seq [4] = '{2'd0, 2'd1, 2'd2, 2'd0};

    // clock / reset
    always #5 clk = ~clk;

    arbitrated_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
        .clk(clk), .reset(reset), .mode(mode), .addr(addr),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef ARBMUX_COUNT_EN
        , .grant_cnt(grant_cnt)
`endif
    );

    arbitrated_mux #(.WIDTH(WIDTH), .NUM_IN(3)) dut3 (
        .clk(clk), .reset(reset), .mode(d3_mode), .addr(d3_addr),
        .in_data(d3_in_data), .in_valid(d3_in_valid), .in_ready(d3_in_ready),
        .out_data(d3_out_data), .out_chan(d3_out_chan), .out_valid(d3_out_valid),
        .out_ready(d3_out_ready)
`ifdef ARBMUX_COUNT_EN
        , .grant_cnt(d3_grant_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic m, input logic [SEL_W-1:0] a,
                         input logic [NUM_IN-1:0] v, input logic r);
        mode      = m;
        addr      = a;
        in_valid  = v;
        out_ready = r;
    endtask

    task automatic set_data(input logic [WIDTH-1:0] base);
        for (int i = 0; i < NUM_IN; i++) begin
            in_data[i*WIDTH +: WIDTH] = base + WIDTH'(i);
        end
    endtask

    // scoreboard: model grant on the falling edge, push the word that will load at the next rising edge
    always @(negedge clk) begin : mon
        logic [NUM_IN-1:0] eg;
        logic              hit;
        logic [SEL_W-1:0]  s;
        int                c;
        if (reset) begin
            chk("rst_in_ready", 64'(in_ready), 64'(0));
            chk("rst_out_valid", 64'(out_valid), 64'(0));
            chk("rst_out_data", 64'(out_data), 64'(0));
            chk("rst_out_chan", 64'(out_chan), 64'(0));
            exp_q.delete();
            m_last = SEL_W'(NUM_IN - 1);
            h_data = '0;
            h_chan = '0;
        end else begin
            if (exp_q.size() != 0) begin
                chk("sb_out_valid", 64'(out_valid), 64'(1));
                chk("sb_out_data", 64'(out_data), 64'(exp_q[0][WIDTH-1:0]));
                chk("sb_out_chan", 64'(out_chan), 64'(exp_q[0][W-1:WIDTH]));
            end else begin
                chk("sb_out_valid", 64'(out_valid), 64'(0));
                chk("sb_hold_data", 64'(out_data), 64'(h_data));
                chk("sb_hold_chan", 64'(out_chan), 64'(h_chan));
            end
            eg  = '0;
            hit = 1'b0;
            s   = '0;
            if (!mode) begin
                if (int'(addr) < NUM_IN && in_valid[addr]) begin
                    hit = 1'b1;
                    s   = addr;
                end
            end else begin
                for (int k = 1; k <= NUM_IN; k++) begin
                    c = (int'(m_last) + k) % NUM_IN;
                    if (!hit && in_valid[c]) begin
                        hit = 1'b1;
                        s   = c[SEL_W-1:0];
                    end
                end
            end
            if (hit && (exp_q.size() == 0 || out_ready)) eg[s] = 1'b1;
            chk("sb_in_ready", 64'(in_ready), 64'(eg));
            if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
            if (eg != 0) begin
                h_data = in_data[int'(s)*WIDTH +: WIDTH];
                h_chan = s;
                exp_q.push_back({s, h_data});
                if (mode) m_last = s;
            end
        end
    end

    initial begin
        reset = 1'b1;
        in_data = '0;
        set_data(8'h10);
        drive(1'b1, 2'd0, 4'hF, 1'b1);
        d3_mode = 1'b0;
        d3_addr = 2'd3;
        d3_in_valid = 3'b111;
        d3_out_ready = 1'b1;
        d3_in_data = {8'hC2, 8'hC1, 8'hC0};
        #3;
        chk("init_in_ready", 64'(in_ready), 64'(0));
        chk("init_out_valid", 64'(out_valid), 64'(0));
        tick();
        tick();
        reset = 1'b0;

        // round-robin over all four, first grant after reset is channel 0
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_chan", 64'(out_chan), 64'(rr_seq[i]));
            chk("rr_data", 64'(out_data), 64'(8'h10 + 8'(rr_seq[i])));
        end

        drive(1'b1, 2'd0, 4'b1010, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("sparse_chan", 64'(out_chan), 64'(sp_seq[i]));
        end
        drive(1'b1, 2'd0, 4'b0010, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("single_chan", 64'(out_chan), 64'(1));
        end

        // addressed mode
        set_data(8'hA0);
        drive(1'b0, 2'd2, 4'hF, 1'b1);
        #1;
        chk("addr_in_ready", 64'(in_ready), 64'(4'b0100));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("addr_data", 64'(out_data), 64'(8'hA2));
            chk("addr_chan", 64'(out_chan), 64'(2));
            chk("addr_ready_run", 64'(in_ready), 64'(4'b0100));
        end

        // backpressure with mode/addr churn while held
        set_data(8'h59);
        drive(1'b0, 2'd1, 4'b0010, 1'b1);
        tick();
        chk("bp_load", 64'(out_data), 64'(8'h5A));
        for (int i = 0; i < 10; i++) begin
            drive(i[0], i[1:0], 4'hF, 1'b0);
            #1;
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_hold_data", 64'(out_data), 64'(8'h5A));
            chk("bp_hold_valid", 64'(out_valid), 64'(1));
            tick();
        end
        drive(1'b0, 2'd3, 4'hF, 1'b1);
        #1;
        chk("refill_in_ready", 64'(in_ready), 64'(4'b1000));
        tick();
        chk("refill_data", 64'(out_data), 64'(8'h5C));
        chk("refill_chan", 64'(out_chan), 64'(3));
        chk("refill_valid", 64'(out_valid), 64'(1));
        drive(1'b0, 2'd3, 4'b0000, 1'b1);
        tick();
        chk("drain_valid", 64'(out_valid), 64'(0));
        chk("drain_hold", 64'(out_data), 64'(8'h5C));

        // three inputs: out-of-range address never grants, round-robin wraps at 3
        chk("d3_bad_addr_ready", 64'(d3_in_ready), 64'(0));
        tick();
        chk("d3_bad_addr_valid", 64'(d3_out_valid), 64'(0));
        d3_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("d3_rr_chan", 64'(d3_out_chan), 64'(d3_seq[i]));
        end

        // reset while the output register is full
        set_data(8'h30);
        drive(1'b1, 2'd0, 4'hF, 1'b1);
        tick();
        chk("pre_rst_valid", 64'(out_valid), 64'(1));
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_data", 64'(out_data), 64'(0));
        chk("mid_rst_ready", 64'(in_ready), 64'(0));
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_chan", 64'(out_chan), 64'(0));
        chk("post_rst_data", 64'(out_data), 64'(8'h30));

        // random traffic checked by the scoreboard
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < NUM_IN; k++) begin
                in_data[k*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 255));
            end
            drive(1'($urandom_range(0, 1)), SEL_W'($urandom_range(0, NUM_IN - 1)),
                  NUM_IN'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
            tick();
        end

`ifdef ARBMUX_COUNT_EN
        drive(1'b0, 2'd0, 4'b0000, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("cnt_reset", 64'(grant_cnt), 64'(0));
        drive(1'b0, 2'd0, 4'b0001, 1'b1);
        repeat (100) tick();
        chk("cnt_100", 64'(grant_cnt[15:0]), 64'(100));
        repeat (69900) tick();
        chk("cnt_sat", 64'(grant_cnt[15:0]), 64'(16'hFFFF));
        chk("cnt_others", 64'(grant_cnt[63:16]), 64'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
